timer_nch: RTL and testbench
============================

# timer_nch

Multi-channel memory-mapped timer that replaces the single-comparator timer as a bus device in the simple system. One shared 64-bit time counter runs behind a programmable prescaler. `NrChannels` independent 64-bit comparators each support one-shot or auto-reloading periodic mode and drive a maskable interrupt. It sits on the system bus as a device with the standard req/we/be/addr/wdata → rvalid/rdata/err handshake, and feeds per-channel and combined interrupts to the core.

## Interface
- `DataWidth`, default 32: bus data width. Only 32 is supported.
- `AddressWidth`, default 32: bus address width. Only `addr_i[9:2]` is decoded.
- `NrChannels`, default 4: number of comparator channels, legal range 1..8.
- `PrescaleWidth`, default 16: width of the PRESCALE register and the prescale counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `timer_req_i`  in  1  bus request, single cycle per access.
- `timer_we_i`  in  1  1 = write, 0 = read.
- `timer_be_i`  in  4  write byte enables.
- `timer_addr_i`  in  AddressWidth  byte address.
- `timer_wdata_i`  in  DataWidth  write data.
- `timer_rvalid_o`  out  1  response valid.
- `timer_rdata_o`  out  DataWidth  read data.
- `timer_err_o`  out  1  error response, qualified by `timer_rvalid_o`.
- `timer_intr_o`  out  NrChannels  per-channel interrupt.
- `timer_irq_o`  out  1  OR of `timer_intr_o`.

## Operation
Register map (offset is `addr[9:0]`):
- Global registers:
  - 0x000 MTIME_LO, RW.
  - 0x004 MTIME_HI, RW.
  - 0x008 PRESCALE, RW, bits [PrescaleWidth-1:0].
  - 0x00C GCTRL, bit0 = count enable.
- Channel c, base 0x100 + 0x20*c:
  - +0x00 CMP_LO, RW.
  - +0x04 CMP_HI, RW.
  - +0x08 PERIOD, RW, 32-bit.
  - +0x0C CTRL: bit0 en, bit1 periodic, bit2 ie.
  - +0x10 STATUS: bit0 pending, W1C.

Register behaviour:
- Unused register bits read 0.
- Writes honour `timer_be_i` per byte.
- Any other offset, including a channel index ≥ NrChannels, is an error access: the write is dropped, rdata = 0, err = 1.

Prescaler and counter:
- When GCTRL.en = 1, the prescale counter increments each cycle.
- When the prescale counter equals PRESCALE, it generates a tick and clears to 0. On a tick, mtime increments by 1, wrapping 2^64−1 → 0.
- PRESCALE = 0 gives a tick every cycle.
- GCTRL.en = 0 freezes both the prescale counter and mtime.
- A bus write to MTIME_LO/HI wins over a tick in the same cycle. The prescale counter is cleared on any PRESCALE write.

Channel compare (evaluated every cycle on registered values):
- hit_c = CTRL.en & (mtime ≥ CMP), unsigned 64-bit compare.
- hit_c sets pending on the next edge. If a set and a W1C land in the same cycle, the set wins.
- One-shot mode (periodic = 0): pending re-sets after a clear as long as hit_c holds. Software must raise CMP or clear en to silence the channel.
- Periodic mode (periodic = 1, PERIOD ≠ 0): on the edge where hit_c sets pending, CMP ← CMP + zero-extended PERIOD, mod 2^64. The channel therefore fires once per PERIOD ticks.
- Periodic with PERIOD = 0 behaves as one-shot.
- A bus write to CMP_LO/HI in the same cycle as a reload wins over the reload, per written byte.

Interrupts:
- `timer_intr_o[c]` = pending_c & ie_c, driven from flops with no extra delay.
- `timer_irq_o` = |`timer_intr_o`.

## Timing
- Reset values: all registers, prescale counter, pending bits and outputs are 0. `timer_rvalid_o`, `timer_err_o`, `timer_rdata_o`, `timer_intr_o` and `timer_irq_o` are all 0 after reset.
- Bus access: `timer_req_i` in cycle N produces `timer_rvalid_o` = 1 in cycle N+1, for both reads and writes, with no stall. Back-to-back requests are accepted every cycle.
- Read data reflects register state at the edge that ends cycle N. A write in cycle N is visible to a read issued in cycle N+1.
- Compare latency: mtime becomes ≥ CMP at edge E, pending sets at edge E+1, and `timer_intr_o` is high after E+1.
- Periodic reload takes effect at the same edge E+1.
- Reset asserted mid-operation takes effect at the next edge. It clears everything, including any response in flight: `timer_rvalid_o` = 0 in the cycle after reset.

## Test plan
- Reset, then read MTIME_LO, GCTRL, ch0 STATUS → each rvalid one cycle after req, rdata = 0, err = 0. All interrupt outputs are 0.
- PRESCALE = 3, GCTRL = 1, then run 40 cycles → MTIME_LO = 10 (±1 for the enable edge), advancing exactly once per 4 cycles.
- ch1: CMP = 20, CTRL = en|ie, PRESCALE = 0 → `timer_intr_o[1]` rises 1 cycle after mtime reaches 20. W1C STATUS → pending re-sets the next cycle. Writing CMP_LO = 1000 and then W1C → stays clear.
- ch0: CMP = 10, PERIOD = 5, CTRL = en|periodic|ie → pending at mtime 10, 15, 20 after each W1C. CMP_LO reads 15, 20, 25.
- MTIME = 0xFFFF_FFFF_FFFF_FFFE, enable → wraps to 0 after 2 ticks. A channel with CMP = 0xFFFF_FFFF_FFFF_FFFF fires at the wrap-1 value.
- Read offset 0x1A0 with NrChannels = 4, then write 0x00C with be = 4'b0010 → the first access gets err = 1 and rdata = 0. The second leaves GCTRL.en unchanged.

Source files
------------

// File: rtl/timer_nch.sv
// rtl/timer_nch.sv - multi-channel memory-mapped 64-bit timer with prescaler and comparators
module timer_nch #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int NrChannels    = 4,
    parameter int PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    timer_req_i,
    input  logic                    timer_we_i,
    input  logic [3:0]              timer_be_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic [NrChannels-1:0]   timer_intr_o,
    output logic                    timer_irq_o
);

    // PRESCALE is held in a 32-bit register whose bits above PrescaleWidth stay zero.
    localparam logic [31:0] PreMask = (PrescaleWidth >= 32) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << PrescaleWidth) - 64'd1);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    // Address decode on the word index addr[9:2].
    logic [7:0] widx;
    logic [2:0] ch_sel;
    logic [2:0] ch_reg;
    logic       is_glb;
    logic       is_chn;
    logic       addr_ok;
    logic       wr_en;
    logic       unused_addr;

    assign widx    = timer_addr_i[9:2];
    assign ch_sel  = widx[5:3];
    assign ch_reg  = widx[2:0];
    assign is_glb  = (widx[7:2] == 6'd0);
    assign is_chn  = (widx[7:6] == 2'b01) && ({29'd0, ch_sel} < 32'(NrChannels)) && (ch_reg <= 3'd4);
    assign addr_ok = is_glb | is_chn;
    assign wr_en   = timer_req_i & timer_we_i & addr_ok;
    assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};

    logic wr_mtime_lo, wr_mtime_hi, wr_prescale, wr_gctrl;
    assign wr_mtime_lo = wr_en & is_glb & (widx[1:0] == 2'd0);
    assign wr_mtime_hi = wr_en & is_glb & (widx[1:0] == 2'd1);
    assign wr_prescale = wr_en & is_glb & (widx[1:0] == 2'd2);
    assign wr_gctrl    = wr_en & is_glb & (widx[1:0] == 2'd3);

    // Global state.
    logic [63:0]              mtime_q;
    logic [63:0]              mtime_next;
    logic [31:0]              prescale_q;
    logic [PrescaleWidth-1:0] pre_cnt_q;
    logic                     count_en_q;
    logic                     tick;

    assign tick = count_en_q & (32'(pre_cnt_q) == prescale_q);

    // Next mtime: tick increment, then any written bytes override it.
    always_comb begin
        mtime_next = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_mtime_lo) mtime_next[31:0]  = byte_merge(mtime_next[31:0], timer_wdata_i, timer_be_i);
        if (wr_mtime_hi) mtime_next[63:32] = byte_merge(mtime_next[63:32], timer_wdata_i, timer_be_i);
    end

    // Timebase registers: mtime, prescaler and global enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            count_en_q <= 1'b0;
        end else begin
            mtime_q <= mtime_next;
            if (wr_prescale) begin
                prescale_q <= byte_merge(prescale_q, timer_wdata_i, timer_be_i) & PreMask;
                pre_cnt_q  <= '0;
            end else if (tick) begin
                pre_cnt_q  <= '0;
            end else if (count_en_q) begin
                pre_cnt_q  <= pre_cnt_q + PrescaleWidth'(1);
            end
            if (wr_gctrl && timer_be_i[0]) begin
                count_en_q <= timer_wdata_i[0];
            end
        end
    end

    // Per-channel values gathered for the read mux.
    logic [63:0]           cmp_v    [NrChannels];
    logic [31:0]           period_v [NrChannels];
    logic [2:0]            ctrl_v   [NrChannels];
    logic [NrChannels-1:0] pending_v;

    for (genvar c = 0; c < NrChannels; c++) begin : gen_ch
        logic        wr_ch;
        logic        en_q, periodic_q, ie_q, pending_q;
        logic [63:0] cmp_q, cmp_next;
        logic [31:0] period_q;
        logic        hit;
        logic        reload;
        logic        w1c;

        assign wr_ch  = wr_en & is_chn & (ch_sel == 3'(c));
        assign hit    = en_q & (mtime_q >= cmp_q);
        assign reload = hit & periodic_q & (period_q != 32'd0);
        assign w1c    = wr_ch & (ch_reg == 3'd4) & timer_be_i[0] & timer_wdata_i[0];

        // Comparator: periodic reload first, bus-written bytes take precedence.
        always_comb begin
            cmp_next = reload ? cmp_q + {32'd0, period_q} : cmp_q;
            if (wr_ch && ch_reg == 3'd0) cmp_next[31:0]  = byte_merge(cmp_next[31:0], timer_wdata_i, timer_be_i);
            if (wr_ch && ch_reg == 3'd1) cmp_next[63:32] = byte_merge(cmp_next[63:32], timer_wdata_i, timer_be_i);
        end

        // Channel registers; a compare hit beats a same-cycle W1C.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cmp_q      <= '0;
                period_q   <= '0;
                en_q       <= 1'b0;
                periodic_q <= 1'b0;
                ie_q       <= 1'b0;
                pending_q  <= 1'b0;
            end else begin
                cmp_q     <= cmp_next;
                pending_q <= hit | (pending_q & ~w1c);
                if (wr_ch && ch_reg == 3'd2) begin
                    period_q <= byte_merge(period_q, timer_wdata_i, timer_be_i);
                end
                if (wr_ch && ch_reg == 3'd3 && timer_be_i[0]) begin
                    {ie_q, periodic_q, en_q} <= timer_wdata_i[2:0];
                end
            end
        end

        assign cmp_v[c]        = cmp_q;
        assign period_v[c]     = period_q;
        assign ctrl_v[c]       = {ie_q, periodic_q, en_q};
        assign pending_v[c]    = pending_q;
        assign timer_intr_o[c] = pending_q & ie_q;
    end

    assign timer_irq_o = |timer_intr_o;

    // Read data mux over current register state.
    logic [DataWidth-1:0] rd_data;
    logic [63:0]          sel_cmp;
    logic [31:0]          sel_period;
    logic [2:0]           sel_ctrl;
    logic                 sel_pending;

    always_comb begin
        rd_data     = '0;
        sel_cmp     = '0;
        sel_period  = '0;
        sel_ctrl    = '0;
        sel_pending = 1'b0;
        for (int c = 0; c < NrChannels; c++) begin
            if (ch_sel == 3'(c)) begin
                sel_cmp     = cmp_v[c];
                sel_period  = period_v[c];
                sel_ctrl    = ctrl_v[c];
                sel_pending = pending_v[c];
            end
        end
        if (is_glb) begin
            case (widx[1:0])
                2'd0:    rd_data = mtime_q[31:0];
                2'd1:    rd_data = mtime_q[63:32];
                2'd2:    rd_data = prescale_q;
                default: rd_data = {31'd0, count_en_q};
            endcase
        end else if (is_chn) begin
            case (ch_reg)
                3'd0:    rd_data = sel_cmp[31:0];
                3'd1:    rd_data = sel_cmp[63:32];
                3'd2:    rd_data = sel_period;
                3'd3:    rd_data = {29'd0, sel_ctrl};
                default: rd_data = {31'd0, sel_pending};
            endcase
        end
    end

    // Bus response, one cycle after every request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_rvalid_o <= 1'b0;
            timer_err_o    <= 1'b0;
            timer_rdata_o  <= '0;
        end else begin
            timer_rvalid_o <= timer_req_i;
            timer_err_o    <= timer_req_i & ~addr_ok;
            timer_rdata_o  <= (timer_req_i && !timer_we_i && addr_ok) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_timer_nch.sv
// tb/tb_timer_nch.sv - self-checking bench for timer_nch
module tb_timer_nch;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic           rvalid;
    logic [31:0]    rdata;
    logic           err;
    logic [NCH-1:0] intr;
    logic           irq;

    timer_nch dut (
        .clk_i(clk), .rst_i(rst),
        .timer_req_i(req), .timer_we_i(we), .timer_be_i(be),
        .timer_addr_i(addr), .timer_wdata_i(wdata),
        .timer_rvalid_o(rvalid), .timer_rdata_o(rdata), .timer_err_o(err),
        .timer_intr_o(intr), .timer_irq_o(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file plus timebase, advanced once per rising edge.
    logic [63:0] m_mtime;
    logic [31:0] m_pre, m_pcnt;
    bit          m_gen;
    logic [63:0] m_cmp [NCH];
    logic [31:0] m_per [NCH];
    logic [2:0]  m_ctl [NCH];
    bit          m_pend [NCH];
    bit          e_rvalid, e_err, e_read, mready = 0;
    logic [31:0] e_rd;

    function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic bit m_valid(input int o);
        if (o <= 'hC) return 1;
        return (o >= 'h100) && (o < 'h100 + 'h20 * NCH) && ((o & 'h1F) <= 'h10);
    endfunction

    function automatic logic [31:0] m_read(input int o);
        int c;
        case (o)
            'h0: return m_mtime[31:0];
            'h4: return m_mtime[63:32];
            'h8: return m_pre;
            'hC: return {31'd0, m_gen};
            default: ;
        endcase
        c = (o - 'h100) / 'h20;
        case (o & 'h1F)
            'h0:  return m_cmp[c][31:0];
            'h4:  return m_cmp[c][63:32];
            'h8:  return m_per[c];
            'hC:  return {29'd0, m_ctl[c]};
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    task automatic m_step();
        logic [63:0] old_mtime;
        logic [31:0] wd;
        logic [3:0]  b;
        bit tick, ok, wr, hit;
        int o, c;
        if (rst) begin
            m_mtime = 0; m_pre = 0; m_pcnt = 0; m_gen = 0;
            e_rvalid = 0; e_err = 0; e_read = 0; e_rd = 0;
            for (int i = 0; i < NCH; i++) begin
                m_cmp[i] = 0; m_per[i] = 0; m_ctl[i] = 0; m_pend[i] = 0;
            end
            mready = 1;
            return;
        end
        o  = int'(addr[9:0]) & 'h3FC;
        ok = m_valid(o);
        wr = req && we && ok;
        wd = wdata;
        b  = be;
        e_rvalid = req;
        e_err    = req && !ok;
        e_read   = req && !we;
        e_rd     = (req && !we && ok) ? m_read(o) : 32'd0;
        old_mtime = m_mtime;
        tick = m_gen && (m_pcnt == m_pre);
        if (tick) m_mtime = m_mtime + 64'd1;
        if (m_gen) m_pcnt = tick ? 32'd0 : m_pcnt + 32'd1;
        for (int i = 0; i < NCH; i++) begin
            hit = m_ctl[i][0] && (old_mtime >= m_cmp[i]);
            if (hit) begin
                m_pend[i] = 1;
                if (m_ctl[i][1] && m_per[i] != 0) m_cmp[i] = m_cmp[i] + {32'd0, m_per[i]};
            end else if (wr && o == 'h110 + 'h20 * i && b[0] && wd[0]) begin
                m_pend[i] = 0;
            end
        end
        if (wr) begin
            if (o == 'h0)      m_mtime[31:0]  = bm(m_mtime[31:0], wd, b);
            else if (o == 'h4) m_mtime[63:32] = bm(m_mtime[63:32], wd, b);
            else if (o == 'h8) begin m_pre = bm(m_pre, wd, b) & 32'h0000_FFFF; m_pcnt = 0; end
            else if (o == 'hC) begin if (b[0]) m_gen = wd[0]; end
            else begin
                c = (o - 'h100) / 'h20;
                case (o & 'h1F)
                    'h0: m_cmp[c][31:0]  = bm(m_cmp[c][31:0], wd, b);
                    'h4: m_cmp[c][63:32] = bm(m_cmp[c][63:32], wd, b);
                    'h8: m_per[c] = bm(m_per[c], wd, b);
                    'hC: if (b[0]) m_ctl[c] = wd[2:0];
                    default: ;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // Per-cycle comparison of DUT outputs against the model, mid-cycle.
    initial forever begin
        logic [NCH-1:0] ei;
        @(negedge clk);
        if (mready) begin
            for (int i = 0; i < NCH; i++) ei[i] = m_pend[i] && m_ctl[i][2];
            chk("cyc_rvalid", rvalid, e_rvalid);
            if (e_rvalid) chk("cyc_err", err, e_err);
            if (e_rvalid && e_read) chk("cyc_rdata", rdata, e_rd);
            chk("cyc_intr", intr, ei);
            chk("cyc_irq", irq, |ei);
        end
    end

    logic [31:0] last_rdata;
    logic        last_err, last_rvalid;

    task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(posedge clk); #2;
        req = 1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #2;
        req = 0; we = 0;
        last_rdata = rdata; last_err = err; last_rvalid = rvalid;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        acc(1, a, d, 4'hF);
    endtask

    task automatic rd32(input logic [31:0] a);
        acc(0, a, 32'd0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_intr(input int ch, input int bound, input string name);
        int n = 0;
        while (!intr[ch] && n < bound) begin
            @(posedge clk); #2;
            n++;
        end
        chk(name, intr[ch], 1'b1);
    endtask

    logic [31:0] r1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1; req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        idle(3);
        rst = 0;

        // Reset state
        chk("rst_intr", intr, 0);
        chk("rst_irq", irq, 0);
        rd32(32'h000);
        chk("rst_mtime_rvalid", last_rvalid, 1); chk("rst_mtime", last_rdata, 0); chk("rst_mtime_err", last_err, 0);
        rd32(32'h00C);
        chk("rst_gctrl", last_rdata, 0); chk("rst_gctrl_err", last_err, 0);
        rd32(32'h110);
        chk("rst_status0", last_rdata, 0); chk("rst_status0_err", last_err, 0);

        // Prescaler 3: one tick per 4 cycles
        wr32(32'h008, 32'd3);
        wr32(32'h00C, 32'd1);
        idle(39);
        rd32(32'h000);
        r1 = last_rdata;
        chk("presc_mtime_about_10", (r1 >= 9 && r1 <= 11), 1);
        idle(2);
        rd32(32'h000);
        chk("presc_step_4cyc", last_rdata - r1, 1);

        // One-shot channel 1
        wr32(32'h00C, 32'd0);
        wr32(32'h000, 32'd0);
        wr32(32'h004, 32'd0);
        wr32(32'h008, 32'd0);
        wr32(32'h120, 32'd20);
        wr32(32'h124, 32'd0);
        wr32(32'h12C, 32'd5);
        wr32(32'h00C, 32'd1);
        wait_intr(1, 100, "os_intr_rise");
        rd32(32'h130);
        chk("os_status_set", last_rdata, 1);
        wr32(32'h130, 32'd1);
        rd32(32'h130);
        chk("os_status_reset", last_rdata, 1);
        wr32(32'h120, 32'd1000);
        wr32(32'h130, 32'd1);
        rd32(32'h130);
        chk("os_status_clear", last_rdata, 0);
        chk("os_intr_low", intr[1], 0);

        // Periodic channel 0, prescale 9 (one tick per 10 cycles)
        wr32(32'h00C, 32'd0);
        wr32(32'h12C, 32'd0);
        wr32(32'h000, 32'd0);
        wr32(32'h004, 32'd0);
        wr32(32'h008, 32'd9);
        wr32(32'h100, 32'd10);
        wr32(32'h104, 32'd0);
        wr32(32'h108, 32'd5);
        wr32(32'h10C, 32'd7);
        wr32(32'h00C, 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_intr(0, 300, "per_intr_rise");
            rd32(32'h000);
            chk("per_mtime", last_rdata, 32'(10 + 5 * k));
            rd32(32'h100);
            chk("per_cmp_lo", last_rdata, 32'(15 + 5 * k));
            chk("per_model_cmp", m_cmp[0], 64'(15 + 5 * k));
            wr32(32'h110, 32'd1);
            rd32(32'h110);
            chk("per_status_clear", last_rdata, 0);
        end

        // 64-bit wrap; channel 2 at all-ones
        wr32(32'h00C, 32'd0);
        wr32(32'h10C, 32'd0);
        wr32(32'h000, 32'hFFFF_FFFE);
        wr32(32'h004, 32'hFFFF_FFFF);
        wr32(32'h008, 32'd0);
        wr32(32'h140, 32'hFFFF_FFFF);
        wr32(32'h144, 32'hFFFF_FFFF);
        wr32(32'h14C, 32'd5);
        chk("wrap_pre_intr", intr, 0);
        wr32(32'h00C, 32'd1);
        wr32(32'h00C, 32'd0);
        chk("wrap_model_mtime", m_mtime, 64'd0);
        rd32(32'h000);
        chk("wrap_mtime_lo", last_rdata, 0);
        rd32(32'h004);
        chk("wrap_mtime_hi", last_rdata, 0);
        rd32(32'h150);
        chk("wrap_ch2_status", last_rdata, 1);
        chk("wrap_ch2_intr", intr[2], 1);

        // Error accesses
        wr32(32'h00C, 32'd1);
        rd32(32'h1A0);
        chk("err_rd_err", last_err, 1);
        chk("err_rd_data", last_rdata, 0);
        acc(1, 32'h00C, 32'd0, 4'b0010);
        chk("be_wr_err", last_err, 0);
        rd32(32'h00C);
        chk("be_gctrl_kept", last_rdata, 1);
        rd32(32'h114);
        chk("err_reg5", last_err, 1);
        wr32(32'h010, 32'hFFFF_FFFF);
        chk("err_wr_glb", last_err, 1);

        // Reset with a request in flight
        @(posedge clk); #2;
        req = 1; we = 0; addr = 32'h000; rst = 1;
        @(posedge clk); #2;
        req = 0; rst = 0;
        chk("rst_flight_rvalid", rvalid, 0);
        chk("rst_flight_intr", intr, 0);
        rd32(32'h00C);
        chk("rst_flight_gctrl", last_rdata, 0);
        rd32(32'h150);
        chk("rst_flight_status2", last_rdata, 0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
